// File: rtl/rcv_timer_pkg.sv
// rcv_timer_pkg: shared state encoding and bit-timing helper for the receive bit timer.
// Revision 1.0 - initial release.
`default_nettype none

package rcv_timer_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_HALF = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    DONE       = 3'd4
  } rcv_state_t;

  // Half a bit period, never shorter than one cycle.
  function automatic int half_bit(input int clks);
    return (clks / 2 > 1) ? clks / 2 : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rcv_bit_timer_tick.sv
// bit_tick_gen: cycle counter with clear/enable, wrapping at a terminal value.
// Revision 1.0 - initial release.
`default_nettype none

module bit_tick_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] terminal,
  output logic             at_terminal
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (en) begin
      count_next = at_terminal ? '0 : count + 1'b1;
    end
  end

  // terminal describes the period that follows this edge, so the flag is
  // valid in the same cycle the counter reaches it.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count       <= '0;
      at_terminal <= 1'b0;
    end else begin
      count       <= count_next;
      at_terminal <= (count_next == terminal);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rcv_bit_timer.sv
// rcv_bit_timer: centres on the start bit, strobes each data bit, checks the stop bit.
// Revision 1.0 - initial release.
`default_nettype none

module rcv_bit_timer
  import rcv_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_detected,
  input  logic serial_in,
  input  logic abort,
  output logic shift_strobe,
  output logic packet_done,
  output logic framing_error,
  output logic timer_active
);

  localparam int HALF_BIT = half_bit(CLKS_PER_BIT);
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int BIT_W    = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_TERM  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  rcv_state_t       state;
  logic [BIT_W-1:0] bit_cnt;
  logic             tick_clear;
  logic             tick_en;
  logic             at_term;
  logic [CNT_W-1:0] tick_term;

  // The terminal presented here belongs to the period after the next edge:
  // half a bit when entering START_HALF, a full bit once leaving it.
  always_comb begin
    tick_clear = abort || (state == IDLE) || (state == DONE);
    tick_en    = (state == START_HALF) || (state == DATA) || (state == STOP);
    tick_term  = ((state == IDLE) || ((state == START_HALF) && !at_term))
                 ? HALF_TERM : BIT_TERM;
  end

  bit_tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (tick_clear),
    .en          (tick_en),
    .terminal    (tick_term),
    .at_terminal (at_term)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      framing_error <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_detected) begin
            state         <= START_HALF;
            bit_cnt       <= '0;
            framing_error <= 1'b0;
          end
        end
        START_HALF: begin
          if (at_term) state <= DATA;
        end
        DATA: begin
          if (at_term) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= STOP;
          end
        end
        STOP: begin
          if (at_term) begin
            framing_error <= ~serial_in;
            state         <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign shift_strobe = (state == DATA) && at_term;
  assign packet_done  = (state == DONE);
  assign timer_active = (state == START_HALF) || (state == DATA) || (state == STOP);

endmodule

`default_nettype wire

// File: tb/tb_rcv_bit_timer.sv
// tb_rcv_bit_timer: two parameterisations driven together, checked against a frame-time model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_rcv_bit_timer;

  logic clk = 1'b0;
  logic n_rst, start_detected, serial_in, abort;
  logic a_strobe, a_done, a_fe, a_active;
  logic b_strobe, b_done, b_fe, b_active;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int base;
  int a_strobe_q[$], a_done_q[$];
  int b_strobe_q[$], b_done_q[$];

  // Model state: frame in flight, elapsed cycle within the frame (1 = first
  // START_HALF cycle), and the sticky framing error.
  bit m_act[2];
  int m_e[2];
  bit m_fe[2];
  int HB[2] = '{5, 1};
  int CB[2] = '{10, 3};
  int DB[2] = '{8, 1};

  always #5 clk = ~clk;

  rcv_bit_timer #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut_a (
    .clk(clk), .n_rst(n_rst), .start_detected(start_detected), .serial_in(serial_in),
    .abort(abort), .shift_strobe(a_strobe), .packet_done(a_done),
    .framing_error(a_fe), .timer_active(a_active));

  rcv_bit_timer #(.CLKS_PER_BIT(3), .DATA_BITS(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .start_detected(start_detected), .serial_in(serial_in),
    .abort(abort), .shift_strobe(b_strobe), .packet_done(b_done),
    .framing_error(b_fe), .timer_active(b_active));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cyc_of(input int e);
    return e - base + 1;
  endfunction

  always @(posedge clk) begin
    int len;
    bit e_act, e_str, e_done;
    logic [3:0] obs;
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      len = HB[i] + (DB[i] + 1) * CB[i];
      if (!n_rst) begin
        m_act[i] = 1'b0;
        m_fe[i]  = 1'b0;
      end else if (abort) begin
        m_act[i] = 1'b0;
      end else if (m_act[i]) begin
        if (m_e[i] == len) m_fe[i] = ~serial_in;
        if (m_e[i] == len + 1) m_act[i] = 1'b0;
        else m_e[i]++;
      end else if (start_detected) begin
        m_act[i] = 1'b1;
        m_e[i]   = 1;
        m_fe[i]  = 1'b0;
      end
    end
    #1;
    if (a_strobe === 1'b1) a_strobe_q.push_back(edge_n);
    if (a_done === 1'b1) a_done_q.push_back(edge_n);
    if (b_strobe === 1'b1) b_strobe_q.push_back(edge_n);
    if (b_done === 1'b1) b_done_q.push_back(edge_n);
    for (int i = 0; i < 2; i++) begin
      len    = HB[i] + (DB[i] + 1) * CB[i];
      e_act  = m_act[i] && (m_e[i] <= len);
      e_done = m_act[i] && (m_e[i] == len + 1);
      e_str  = m_act[i] && (m_e[i] > HB[i]) && (m_e[i] <= HB[i] + DB[i] * CB[i])
               && ((m_e[i] - HB[i]) % CB[i] == 0);
      obs = (i == 0) ? {a_strobe, a_done, a_fe, a_active}
                     : {b_strobe, b_done, b_fe, b_active};
      check($sformatf("dut%0d shift_strobe", i), obs[3], e_str);
      check($sformatf("dut%0d packet_done", i), obs[2], e_done);
      check($sformatf("dut%0d framing_error", i), obs[1], m_fe[i]);
      check($sformatf("dut%0d timer_active", i), obs[0], e_act);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    a_strobe_q.delete(); a_done_q.delete();
    b_strobe_q.delete(); b_done_q.delete();
  endtask

  // Drive a one-cycle start in the current cycle, which becomes cycle 0.
  task automatic pulse_start();
    clear_logs();
    base = edge_n + 1;
    start_detected = 1'b1;
    tick(1);
    start_detected = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; start_detected = 1'b0; serial_in = 1'b1; abort = 1'b0;
    tick(3);
    check("reset active", a_active, 0);
    check("reset fe", a_fe, 0);
    n_rst = 1'b1;
    tick(2);

    // Nominal frame
    pulse_start();
    tick(100);
    check("nominal strobe count", a_strobe_q.size(), 8);
    for (int k = 0; k < 8 && k < a_strobe_q.size(); k++)
      check($sformatf("nominal strobe %0d cycle", k + 1), cyc_of(a_strobe_q[k]), 15 + 10 * k);
    check("nominal done count", a_done_q.size(), 1);
    if (a_done_q.size() > 0) check("nominal done cycle", cyc_of(a_done_q[0]), 96);
    check("nominal fe", a_fe, 0);
    check("small strobe count", b_strobe_q.size(), 1);
    if (b_strobe_q.size() > 0) check("small strobe cycle", cyc_of(b_strobe_q[0]), 4);
    if (b_done_q.size() > 0) check("small done cycle", cyc_of(b_done_q[0]), 8);

    // Framing error, then cleared by the next accepted start
    serial_in = 1'b0;
    pulse_start();
    tick(100);
    check("framing error set", a_fe, 1);
    serial_in = 1'b1;
    pulse_start();
    check("framing error cleared", a_fe, 0);
    tick(100);

    // Abort at cycle 40, restart at cycle 45
    pulse_start();
    tick(39);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(4);
    start_detected = 1'b1;
    tick(1);
    start_detected = 1'b0;
    tick(110);
    check("abort strobe count", a_strobe_q.size(), 11);
    if (a_strobe_q.size() > 3) check("restart first strobe", cyc_of(a_strobe_q[3]), 60);
    check("abort done count", a_done_q.size(), 1);
    if (a_done_q.size() > 0) check("restart done cycle", cyc_of(a_done_q[0]), 141);

    // Start held high across the frame and DONE
    clear_logs();
    base = edge_n + 1;
    start_detected = 1'b1;
    tick(120);
    start_detected = 1'b0;
    tick(200);
    check("held start done count", a_done_q.size(), 2);
    if (a_done_q.size() > 1) begin
      check("held start done 1", cyc_of(a_done_q[0]), 96);
      check("held start done 2", cyc_of(a_done_q[1]), 193);
    end
    if (a_strobe_q.size() > 8) check("held start next strobe", cyc_of(a_strobe_q[8]), 112);

    // Reset mid-frame, then a normal frame
    pulse_start();
    tick(29);
    n_rst = 1'b0;
    tick(2);
    check("mid reset active", a_active, 0);
    check("mid reset strobe", a_strobe, 0);
    n_rst = 1'b1;
    tick(3);
    pulse_start();
    tick(100);
    if (a_strobe_q.size() > 0) check("post reset first strobe", cyc_of(a_strobe_q[0]), 15);
    check("post reset done count", a_done_q.size(), 1);

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      start_detected = ($urandom_range(0, 19) == 0);
      abort          = ($urandom_range(0, 249) == 0);
      n_rst          = !($urandom_range(0, 599) == 0);
      serial_in      = $urandom_range(0, 3) != 0;
      tick(1);
    end
    start_detected = 1'b0; abort = 1'b0; n_rst = 1'b1;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
